fifo_rd_stream: RTL and testbench

FIFO_RD_STREAM -- requirements
Module: fifo_rd_stream

---
 rtl/fifo_rd_stream.sv | 96 +++++++++
 tb/tb_fifo_rd_stream.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_rd_stream.sv
// FIFO read side to valid/ready stream with packet framing; pop in cycle N gives m_valid in N+2, one beat/cycle sustained.
// Backpressure: m_ready low fills a 3-entry skid buffer, then pops stop (pop decision never looks at m_ready).
module fifo_rd_stream #(
    parameter int data_width = 8
) (
    input  logic                  rd_clk,
    input  logic                  rd_reset_n,
    input  logic                  fifo_empty,
    input  logic [data_width-1:0] fifo_data,
    output logic                  fifo_rd_en,
    input  logic                  enable,
    input  logic [7:0]            pkt_len,
    output logic [data_width-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic                  m_last,
    output logic [15:0]           words_out,
    output logic                  busy
);

    logic [data_width-1:0] buf_q [3];
    logic [data_width-1:0] buf_d [3];
    logic [1:0]            occ_q, occ_d, occ_sh;
    logic                  valid_q, valid_d;
    logic                  infl_q;
    logic [7:0]            beat_cnt_q, beat_cnt_d;
    logic [7:0]            pkt_len_q, pkt_len_d;
    logic [15:0]           words_q, words_d;
    logic [2:0]            fill;
    logic                  xfer;

    // Entries already held plus the word in flight must leave room for the pop.
    assign fill       = {1'b0, occ_q} + {2'b00, infl_q};
    assign fifo_rd_en = rd_reset_n && enable && !fifo_empty && (fill < 3'd3);

    assign m_data    = buf_q[0];
    assign m_valid   = valid_q;
    assign m_last    = valid_q && (beat_cnt_q == (pkt_len_q - 8'd1));
    assign words_out = words_q;
    assign busy      = valid_q || infl_q;
    assign xfer      = valid_q && m_ready;

    // Head-at-index-0 shift buffer: shift out on transfer, then append the landed word.
    always_comb begin
        buf_d  = buf_q;
        occ_sh = occ_q;
        occ_d  = occ_q;
        if (xfer) begin
            buf_d[0] = buf_q[1];
            buf_d[1] = buf_q[2];
            occ_sh   = occ_q - 2'd1;
        end
        occ_d = occ_sh;
        if (infl_q) begin
            for (int i = 0; i < 3; i++) begin
                if (occ_sh == 2'(i)) begin
                    buf_d[i] = fifo_data;
                end
            end
            occ_d = occ_sh + 2'd1;
        end
        valid_d = (occ_d != 2'd0);
    end

    always_comb begin
        pkt_len_d  = (beat_cnt_q == 8'd0) ? pkt_len : pkt_len_q;
        beat_cnt_d = beat_cnt_q;
        if (xfer) begin
            beat_cnt_d = m_last ? 8'd0 : beat_cnt_q + 8'd1;
        end
        words_d = words_q + {15'd0, xfer};
    end

    always_ff @(posedge rd_clk or negedge rd_reset_n) begin
        if (!rd_reset_n) begin
            for (int i = 0; i < 3; i++) begin
                buf_q[i] <= '0;
            end
            occ_q      <= 2'd0;
            valid_q    <= 1'b0;
            infl_q     <= 1'b0;
            beat_cnt_q <= 8'd0;
            pkt_len_q  <= 8'd0;
            words_q    <= 16'd0;
        end else begin
            buf_q      <= buf_d;
            occ_q      <= occ_d;
            valid_q    <= valid_d;
            infl_q     <= fifo_rd_en;
            beat_cnt_q <= beat_cnt_d;
            pkt_len_q  <= pkt_len_d;
            words_q    <= words_d;
        end
    end

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Bench for fifo_rd_stream: behavioural FIFO feeding the DUT, scoreboard of expected words and packet framing.
module tb_fifo_rd_stream;

    logic        rd_clk = 1'b0;
    logic        rd_reset_n = 1'b0;
    logic        fifo_empty = 1'b1;
    logic [7:0]  fifo_data = 8'd0;
    logic        fifo_rd_en;
    logic        enable = 1'b0;
    logic [7:0]  pkt_len = 8'd4;
    logic [7:0]  m_data;
    logic        m_valid;
    logic        m_ready = 1'b0;
    logic        m_last;
    logic [15:0] words_out;
    logic        busy;

    fifo_rd_stream #(.data_width(8)) dut (
        .rd_clk     (rd_clk),
        .rd_reset_n (rd_reset_n),
        .fifo_empty (fifo_empty),
        .fifo_data  (fifo_data),
        .fifo_rd_en (fifo_rd_en),
        .enable     (enable),
        .pkt_len    (pkt_len),
        .m_data     (m_data),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_last     (m_last),
        .words_out  (words_out),
        .busy       (busy)
    );

    always #5 rd_clk = ~rd_clk;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] src_q [$];
    logic [7:0] exp_q [$];
    int         tb_len  = 4;
    int         tb_beat = 0;

    int   cyc, pop_cnt, xfer_cnt, last_cnt, viol;
    int   first_pop, first_valid, first_xfer, last_xfer;
    logic busy_after;
    logic prev_stall;
    logic [7:0] prev_data;
    logic prev_last;
    logic tog_en = 1'b0, tog_ph = 1'b0, rand_rdy = 1'b0;

    task automatic clear_stats();
        cyc = 0; pop_cnt = 0; xfer_cnt = 0; last_cnt = 0;
        first_pop = -1; first_valid = -1; first_xfer = -1; last_xfer = -1;
        busy_after = 1'b1;
    endtask

    task automatic load(input int n, input int base, input bit rnd);
        logic [7:0] w;
        for (int i = 0; i < n; i++) begin
            w = rnd ? 8'($urandom) : 8'(base + i);
            src_q.push_back(w);
            exp_q.push_back(w);
        end
        fifo_empty = (src_q.size() == 0);
    endtask

    task automatic do_reset();
        rd_reset_n = 1'b0;
        enable = 1'b0; m_ready = 1'b0; tog_en = 1'b0; rand_rdy = 1'b0;
        src_q.delete(); exp_q.delete();
        fifo_empty = 1'b1;
        prev_stall = 1'b0;
        tb_beat = 0;
        repeat (2) @(posedge rd_clk);
        #1 rd_reset_n = 1'b1;
        clear_stats();
    endtask

    // One clock: sample and score at negedge, then model the FIFO just after the posedge.
    task automatic step();
        logic pop;
        logic [7:0] exp_d;
        logic exp_l;
        @(negedge rd_clk);
        if (fifo_rd_en && fifo_empty) viol++;
        pop = fifo_rd_en;
        if (pop) begin
            pop_cnt++;
            if (first_pop < 0) first_pop = cyc;
        end
        if (m_valid && first_valid < 0) first_valid = cyc;
        if (last_xfer >= 0 && cyc == last_xfer + 1) busy_after = busy;
        if (prev_stall) begin
            n_tests++;
            if (m_valid !== 1'b1 || m_data !== prev_data || m_last !== prev_last) begin
                n_fail++;
                $display("FAIL stall_hold got v=%b d=%h l=%b exp v=1 d=%h l=%b",
                         m_valid, m_data, m_last, prev_data, prev_last);
            end
        end
        prev_stall = m_valid && !m_ready;
        prev_data  = m_data;
        prev_last  = m_last;
        if (m_valid && m_ready) begin
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL beat_extra got d=%h exp no beat", m_data);
            end else begin
                exp_d = exp_q.pop_front();
                exp_l = (tb_beat == tb_len - 1);
                tb_beat = exp_l ? 0 : tb_beat + 1;
                if (m_data !== exp_d || m_last !== exp_l) begin
                    n_fail++;
                    $display("FAIL beat_%0d got d=%h l=%b exp d=%h l=%b",
                             xfer_cnt, m_data, m_last, exp_d, exp_l);
                end
            end
            if (m_last) last_cnt++;
            if (first_xfer < 0) first_xfer = cyc;
            last_xfer = cyc;
            xfer_cnt++;
        end
        cyc++;
        @(posedge rd_clk);
        #1;
        if (pop && src_q.size() != 0) fifo_data = src_q.pop_front();
        fifo_empty = (src_q.size() == 0) || (tog_en && tog_ph);
        tog_ph = ~tog_ph;
        if (rand_rdy) m_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic run_until(input int target, input int budget, input string name);
        for (int i = 0; i < budget && xfer_cnt < target; i++) step();
        n_tests++;
        if (xfer_cnt !== target) begin
            n_fail++;
            $display("FAIL %s_timeout got %0d beats exp %0d", name, xfer_cnt, target);
        end
    endtask

    task automatic test_reset();
        do_reset();
        pkt_len = 8'd3; tb_len = 3;
        load(5, 8'hA0, 1'b0);
        enable = 1'b1; m_ready = 1'b1;
        run_until(1, 20, "rst_pre");
        m_ready = 1'b0;
        step(); step();
        n_tests++;
        if (m_valid !== 1'b1 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_pre_active got v=%b busy=%b exp 1 1", m_valid, busy);
        end
        rd_reset_n = 1'b0;
        #2;
        n_tests++;
        if ({fifo_rd_en, m_valid, m_last, busy} !== 4'b0000) begin
            n_fail++;
            $display("FAIL rst_flags got rd=%b v=%b l=%b busy=%b exp 0", fifo_rd_en, m_valid, m_last, busy);
        end
        n_tests++;
        if (m_data !== 8'd0 || words_out !== 16'd0) begin
            n_fail++;
            $display("FAIL rst_values got d=%h words=%h exp 0 0", m_data, words_out);
        end
        n_tests++;
        if (dut.beat_cnt_q !== 8'd0 || dut.pkt_len_q !== 8'd0) begin
            n_fail++;
            $display("FAIL rst_counters got beat=%h len=%h exp 0 0", dut.beat_cnt_q, dut.pkt_len_q);
        end
        do_reset();
        // After a mid-packet reset the first beat must open a fresh packet.
        pkt_len = 8'd2; tb_len = 2;
        load(2, 8'hC0, 1'b0);
        enable = 1'b1; m_ready = 1'b1;
        run_until(2, 20, "rst_post");
        n_tests++;
        if (last_cnt !== 1 || words_out !== 16'd2) begin
            n_fail++;
            $display("FAIL rst_new_pkt got lasts=%0d words=%0d exp 1 2", last_cnt, words_out);
        end
    endtask

    task automatic test_stream();
        do_reset();
        pkt_len = 8'd4; tb_len = 4;
        load(8, 8'h01, 1'b0);
        enable = 1'b1; m_ready = 1'b1;
        run_until(8, 40, "stream");
        n_tests++;
        if (first_valid - first_pop !== 2) begin
            n_fail++;
            $display("FAIL stream_latency got %0d exp 2", first_valid - first_pop);
        end
        n_tests++;
        if (last_xfer - first_xfer !== 7) begin
            n_fail++;
            $display("FAIL stream_b2b got span %0d exp 7", last_xfer - first_xfer);
        end
        n_tests++;
        if (last_cnt !== 2 || words_out !== 16'd8) begin
            n_fail++;
            $display("FAIL stream_totals got lasts=%0d words=%0d exp 2 8", last_cnt, words_out);
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        pkt_len = 8'd4; tb_len = 4;
        load(10, 8'h10, 1'b0);
        enable = 1'b1; m_ready = 1'b0;
        repeat (10) step();
        n_tests++;
        if (pop_cnt !== 3 || fifo_rd_en !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_pops got pops=%0d rd=%b exp 3 0", pop_cnt, fifo_rd_en);
        end
        n_tests++;
        if (m_valid !== 1'b1 || m_data !== 8'h10) begin
            n_fail++;
            $display("FAIL bp_head got v=%b d=%h exp 1 10", m_valid, m_data);
        end
        m_ready = 1'b1;
        run_until(10, 60, "bp");
        n_tests++;
        if (last_xfer - first_xfer !== 9 || exp_q.size() !== 0) begin
            n_fail++;
            $display("FAIL bp_drain got span=%0d left=%0d exp 9 0", last_xfer - first_xfer, exp_q.size());
        end
    endtask

    task automatic test_pkt_len_zero();
        do_reset();
        pkt_len = 8'd0; tb_len = 256;
        load(300, 8'h00, 1'b1);
        enable = 1'b1; m_ready = 1'b1;
        run_until(300, 400, "len0");
        n_tests++;
        if (last_cnt !== 1 || dut.beat_cnt_q !== 8'd44) begin
            n_fail++;
            $display("FAIL len0_framing got lasts=%0d beat=%0d exp 1 44", last_cnt, dut.beat_cnt_q);
        end
        n_tests++;
        if (words_out !== 16'd300) begin
            n_fail++;
            $display("FAIL len0_words got %0d exp 300", words_out);
        end
    endtask

    task automatic test_enable_off();
        do_reset();
        pkt_len = 8'd8; tb_len = 8;
        load(10, 8'h40, 1'b0);
        enable = 1'b1; m_ready = 1'b0;
        repeat (3) step();
        n_tests++;
        if (dut.occ_q !== 2'd2 || dut.infl_q !== 1'b1 || pop_cnt !== 3) begin
            n_fail++;
            $display("FAIL en_setup got occ=%0d infl=%b pops=%0d exp 2 1 3", dut.occ_q, dut.infl_q, pop_cnt);
        end
        enable = 1'b0; m_ready = 1'b1;
        pop_cnt = 0;
        repeat (8) step();
        n_tests++;
        if (pop_cnt !== 0 || xfer_cnt !== 3 || exp_q.size() !== 7) begin
            n_fail++;
            $display("FAIL en_drain got pops=%0d beats=%0d left=%0d exp 0 3 7", pop_cnt, xfer_cnt, exp_q.size());
        end
        n_tests++;
        if (busy_after !== 1'b0) begin
            n_fail++;
            $display("FAIL en_busy got %b exp 0", busy_after);
        end
    endtask

    task automatic test_random();
        do_reset();
        pkt_len = 8'd5; tb_len = 5;
        viol = 0;
        load(1000, 0, 1'b1);
        tog_en = 1'b1; rand_rdy = 1'b1;
        enable = 1'b1; m_ready = 1'b1;
        run_until(1000, 20000, "rand");
        tog_en = 1'b0; rand_rdy = 1'b0;
        n_tests++;
        if (words_out !== 16'd1000 || exp_q.size() !== 0) begin
            n_fail++;
            $display("FAIL rand_totals got words=%0d left=%0d exp 1000 0", words_out, exp_q.size());
        end
        n_tests++;
        if (viol !== 0) begin
            n_fail++;
            $display("FAIL rd_en_when_empty got %0d exp 0", viol);
        end
    endtask

    initial begin
        viol = 0;
        clear_stats();
        test_reset();
        test_stream();
        test_backpressure();
        test_pkt_len_zero();
        test_enable_off();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
